// File: rtl/cond_pkg.sv
// cond_pkg: NZCV flag bit positions and ARM condition-code encodings
package cond_pkg;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition test; in cond_code[3:0], flags[3:0] (NZCV); out result
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       result
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  always_comb begin
    case (cond_code)
      COND_EQ: result = z;
      COND_NE: result = !z;
      COND_CS: result = c;
      COND_CC: result = !c;
      COND_MI: result = n;
      COND_PL: result = !n;
      COND_VS: result = v;
      COND_VC: result = !v;
      COND_HI: result = c && !z;
      COND_LS: result = !c || z;
      COND_GE: result = n == v;
      COND_LT: result = n != v;
      COND_GT: result = !z && (n == v);
      COND_LE: result = z || (n != v);
      COND_AL: result = 1'b1;
      default: result = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_flag_bank.sv
// cond_flag_bank: live NZCV flags with masked load, banked save/restore, condition evaluation and saturating fail counter; in flags_in/fr_ld/fr_mask/save_en/restore_en/bank_sel/cond_code/cond_valid/cnt_clr, out flags_q/saved_q/cond/cond_out_valid/fail_cnt
module cond_flag_bank
  import cond_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int FWD       = 1,
  parameter int COND_REG  = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        flags_in,
  input  logic              fr_ld,
  input  logic [3:0]        fr_mask,
  input  logic              save_en,
  input  logic              restore_en,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [3:0]        cond_code,
  input  logic              cond_valid,
  input  logic              cnt_clr,
  output logic [3:0]        flags_q,
  output logic [3:0]        saved_q,
  output logic              cond,
  output logic              cond_out_valid,
  output logic [CNT_W-1:0]  fail_cnt
);
  logic [3:0] bank_q [NUM_BANKS];
  logic [3:0] bank_d [NUM_BANKS];
  logic [3:0] flags_d, eff_flags;
  logic bank_ok, res, cond_q, cond_d, cond_vld_q, cond_vld_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  assign bank_ok = 32'(bank_sel) < NUM_BANKS;
  assign saved_q = bank_ok ? bank_q[bank_sel] : 4'b0000;
  always_comb begin
    bank_d = bank_q;
    if (save_en && bank_ok) bank_d[bank_sel] = flags_q;
    flags_d = (restore_en && bank_ok) ? saved_q
            : fr_ld ? (flags_in & fr_mask) | (flags_q & ~fr_mask)
            : flags_q;
  end
  assign eff_flags = (FWD != 0) ? flags_d : flags_q;
  cond_eval u_eval (
    .cond_code (cond_code),
    .flags     (eff_flags),
    .result    (res)
  );
  always_comb begin
    cond_d     = cond_valid ? res : cond_q;
    cond_vld_d = cond_valid;
    fail_cnt_d = cnt_clr ? '0
               : (cond_valid && !res && !(&fail_cnt_q)) ? fail_cnt_q + 1'b1
               : fail_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q    <= 4'b0000;
      bank_q     <= '{default: 4'b0000};
      cond_q     <= 1'b0;
      cond_vld_q <= 1'b0;
      fail_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      bank_q     <= bank_d;
      cond_q     <= cond_d;
      cond_vld_q <= cond_vld_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end
  assign cond           = (COND_REG != 0) ? cond_q : res;
  assign cond_out_valid = (COND_REG != 0) ? cond_vld_q : cond_valid;
  assign fail_cnt       = fail_cnt_q;
endmodule

// File: doc/cond_flag_bank.md
Name: cond_flag_bank

Overview:
Parametrised successor to the single 4-bit flag register and condition tester. It holds the live NZCV flags with per-flag masked update and NUM_BANKS saved flag banks (SPSR-style save/restore). It evaluates all 16 ARM condition codes, with optional forwarding of an in-flight flag write and an optional registered output stage. A saturating counter tracks failed conditions for debug. It sits between the ALU flag outputs and the control unit's instruction-execute decision.

Parameters:
NUM_BANKS, 4, number of saved flag banks (>=1)
BANK_W, 2, width of bank_sel; must equal clog2(NUM_BANKS), minimum 1
FWD, 1, 1 = condition evaluation sees same-cycle flag write/restore result; 0 = sees registered flags only
COND_REG, 1, 1 = cond output registered (1-cycle latency); 0 = combinational (0 latency)
CNT_W, 16, width of fail counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flags_in  in  4  new flags, bit3=N bit2=Z bit1=C bit0=V
fr_ld  in  1  load live flags from flags_in under fr_mask
fr_mask  in  4  per-flag write enable (same bit order)
save_en  in  1  copy live flags into bank[bank_sel]
restore_en  in  1  copy bank[bank_sel] into live flags
bank_sel  in  BANK_W  bank index for save/restore/read
cond_code  in  4  ARM condition field (IR[31:28])
cond_valid  in  1  evaluation request
flags_q  out  4  live flags
saved_q  out  4  bank[bank_sel], combinational read
cond  out  1  condition result
cond_out_valid  out  1  cond qualifier
fail_cnt  out  CNT_W  saturating count of failed evaluations
cnt_clr  in  1  synchronous clear of fail_cnt

Behaviour:
- Reset (async, immediate): flags_q=0000, all banks=0000, cond=0, cond_out_valid=0, fail_cnt=0.
- Live flag next value: restore_en -> bank[bank_sel] (restore overrides fr_ld entirely); else fr_ld -> per bit i: fr_mask[i] ? flags_in[i] : flags_q[i]; else hold.
- fr_ld with fr_mask=0000 -> no change.
- Save: bank[bank_sel] <= current (pre-update) flags_q. A same-cycle fr_ld does not affect the saved value.
- save_en and restore_en together on the same bank -> swap: bank gets old live flags, live gets old bank value.
- bank_sel >= NUM_BANKS -> save ignored, restore ignored (live flags hold, fr_ld still applies), saved_q=0000.
- Effective flags for evaluation: FWD=1 -> next-value of live flags (above); FWD=0 -> flags_q.
- Condition table:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 CS C; 0011 CC !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 0
- COND_REG=1: cond and cond_out_valid register the result and cond_valid. cond holds its last value when cond_valid=0; cond_out_valid=0 in that cycle.
- COND_REG=0: cond is combinational; cond_out_valid=cond_valid.
- fail_cnt increments by 1 each cycle with cond_valid=1 and result 0, evaluated at request time regardless of COND_REG.
- fail_cnt saturates at all-ones.
- cnt_clr has priority over increment (counter becomes 0).

Decomposition:
- Package cond_pkg holds:
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - 4-bit localparams COND_EQ..COND_NV
- Sub-module cond_eval: purely combinational (cond_code, flags) -> result, implementing the table above. It is instantiated once and reusable by the decoder.

Test Plan:
- Reset mid-operation: after flags_q=1111 and bank0=1010, assert rst between edges -> all outputs 0 immediately, fail_cnt=0.
- Masked load: flags_q=0000; fr_ld, flags_in=1111, fr_mask=1110 -> flags_q=1110. Then restore_en and fr_ld together on bank1=0101 -> flags_q=0101.
- Swap: flags_q=1001, bank2=0110; save_en=restore_en=1, bank_sel=2 -> flags_q=0110, saved_q (sel 2)=1001.
- Conditions: sweep all 16 codes over all 16 flag values, compare against table. Spot checks:
  - N=1 V=0: GE=0, LT=1
  - C=0 Z=1: LS=1, HI=0
  - 1111 -> 0
- Forwarding (FWD=1, COND_REG=1): flags_q=0000; same cycle fr_ld with flags_in=0100 mask=1111 and cond_code=EQ -> next cycle cond=1, cond_out_valid=1. With FWD=0 -> cond=0.
- Counter: CNT_W=2; five failing evaluations -> fail_cnt 1,2,3,3,3. cnt_clr with a failing evaluation in the same cycle -> fail_cnt=0.
